// File: rtl/buyruk_hizalayici.sv
// buyruk_hizalayici: second fetch stage. It sits between getir1/L1 instruction
// cache and decode, and turns 32-bit fetch words into RV32IC instructions.
//
// Operation:
//   - Tracks outstanding L1 requests and their PS values in request order.
//   - Splits each returned 32-bit word into 16-bit parcels held in a parcel queue.
//   - Re-assembles compressed and 32-bit instructions, including 32-bit
//     instructions that straddle two fetch words.
//   - Hands one instruction per cycle to decode.
//   - A flush discards the parcel queue and the output register. Responses to
//     requests issued before the flush are then dropped as they come back.
//
// Handshake rule, for both the l1b and coz sides: a transfer happens on a rising
// edge where valid and ready are both high. A holder of valid keeps valid and
// its payload stable until that transfer happens. Ready may be driven
// independently of valid.
//
// Ports:
//   clk_i, rstn_i               clock; synchronous active-low reset
//   g1_istek_yapildi_i          getir1 issued an L1 request this cycle
//   g1_istek_ps_i               PS of that request (bit 0 always 0)
//   g1_istek_izin_o             a new request is permitted (outstanding < MAKS_BEKLEYEN)
//   l1b_buyruk_i                returned fetch word; parcel 0 = [15:0], parcel 1 = [31:16]
//   l1b_buyruk_gecerli_i        response valid
//   l1b_buyruk_hazir_o          response accept
//   coz_buyruk_o                instruction (compressed ones zero-extended in [15:0])
//   coz_buyruk_ps_o             PS of the instruction's first parcel
//   coz_buyruk_sikistirilmis_o  instruction is 16-bit
//   coz_buyruk_gecerli_o        output valid
//   coz_buyruk_hazir_i          decode ready
//   cek_bosalt_i                pipeline flush, single-cycle pulse
module buyruk_hizalayici #(
  parameter int PS_BIT          = 32,
  parameter int KUYRUK_DERINLIK = 8,
  parameter int MAKS_BEKLEYEN   = 3
) (
  input  logic              clk_i,
  input  logic              rstn_i,
  input  logic              g1_istek_yapildi_i,
  input  logic [PS_BIT-1:0] g1_istek_ps_i,
  output logic              g1_istek_izin_o,
  input  logic [31:0]       l1b_buyruk_i,
  input  logic              l1b_buyruk_gecerli_i,
  output logic              l1b_buyruk_hazir_o,
  output logic [31:0]       coz_buyruk_o,
  output logic [PS_BIT-1:0] coz_buyruk_ps_o,
  output logic              coz_buyruk_sikistirilmis_o,
  output logic              coz_buyruk_gecerli_o,
  input  logic              coz_buyruk_hazir_i,
  input  logic              cek_bosalt_i
);

  localparam int QA_W = $clog2(KUYRUK_DERINLIK);
  localparam int QO_W = $clog2(KUYRUK_DERINLIK + 1);
  localparam int BK_W = $clog2(MAKS_BEKLEYEN + 1);
  localparam int RA_W = (MAKS_BEKLEYEN > 1) ? $clog2(MAKS_BEKLEYEN) : 1;

  // ---------------------------------------------------------------------------
  // Request queue and outstanding / drop counters
  // ---------------------------------------------------------------------------
  logic [PS_BIT-1:0] rq_mem_q [MAKS_BEKLEYEN];
  logic [RA_W-1:0]   rq_yaz_q, rq_yaz_d;
  logic [RA_W-1:0]   rq_oku_q, rq_oku_d;
  logic [BK_W-1:0]   bekleyen_q, bekleyen_d;
  logic [BK_W-1:0]   dusur_q, dusur_d;

  logic              istek_kabul;
  logic              yanit_kabul;
  logic              yanit_pop;
  logic              yanit_sakla;
  logic [PS_BIT-1:0] bas_ps;
  logic [PS_BIT-1:0] ps_hizali;
  logic [PS_BIT-1:0] ps_ust;
  logic              unused_ps_bit0;

  // ---------------------------------------------------------------------------
  // Parcel queue
  // ---------------------------------------------------------------------------
  logic [15:0]       pq_veri_q [KUYRUK_DERINLIK];
  logic [PS_BIT-1:0] pq_ps_q   [KUYRUK_DERINLIK];
  logic [QA_W-1:0]   pq_yaz_q, pq_yaz_d;
  logic [QA_W-1:0]   pq_oku_q, pq_oku_d;
  logic [QO_W-1:0]   pq_dolu_q, pq_dolu_d;
  logic [QO_W-1:0]   bos_yer;

  logic              yaz0_en, yaz1_en;
  logic [QA_W-1:0]   yaz0_adr, yaz1_adr;
  logic [15:0]       yaz0_veri, yaz1_veri;
  logic [PS_BIT-1:0] yaz0_ps, yaz1_ps;
  logic [1:0]        yaz_n;
  logic [1:0]        oku_n;

  // ---------------------------------------------------------------------------
  // Output register
  // ---------------------------------------------------------------------------
  logic [31:0]       cb_q, cb_d;
  logic [PS_BIT-1:0] cps_q, cps_d;
  logic              csk_q, csk_d;
  logic              cgec_q, cgec_d;

  logic              cikis_bos;
  logic [15:0]       p0, p1;
  logic              p0_sik;

  function automatic logic [RA_W-1:0] rq_sonraki(input logic [RA_W-1:0] p);
    if (p == RA_W'(MAKS_BEKLEYEN - 1)) begin
      return '0;
    end
    return p + RA_W'(1);
  endfunction

  // Both permissions depend only on registered state (plus reset), so they
  // never depend on same-cycle activity on the other side.
  assign bos_yer            = QO_W'(KUYRUK_DERINLIK) - pq_dolu_q;
  assign g1_istek_izin_o    = (bekleyen_q < BK_W'(MAKS_BEKLEYEN));
  assign l1b_buyruk_hazir_o = rstn_i && ((dusur_q != '0) || (bos_yer >= QO_W'(2)));

  assign istek_kabul = g1_istek_yapildi_i && g1_istek_izin_o;
  assign yanit_kabul = l1b_buyruk_gecerli_i && l1b_buyruk_hazir_o;
  // A response with nothing outstanding cannot be matched to a request, so it
  // neither pops nor counts.
  assign yanit_pop   = yanit_kabul && (bekleyen_q != '0);
  // A response is kept only outside drop mode and outside a flush cycle.
  assign yanit_sakla = yanit_pop && !cek_bosalt_i && (dusur_q == '0);

  assign bas_ps         = rq_mem_q[rq_oku_q];
  assign ps_hizali      = {bas_ps[PS_BIT-1:2], 2'b00};
  assign ps_ust         = {bas_ps[PS_BIT-1:2], 2'b10};
  assign unused_ps_bit0 = bas_ps[0];

  always_comb begin
    rq_yaz_d   = rq_yaz_q;
    rq_oku_d   = rq_oku_q;
    bekleyen_d = bekleyen_q;
    dusur_d    = dusur_q;

    if (istek_kabul) begin
      rq_yaz_d = rq_sonraki(rq_yaz_q);
    end
    if (yanit_pop) begin
      rq_oku_d = rq_sonraki(rq_oku_q);
    end

    case ({istek_kabul, yanit_pop})
      2'b10:   bekleyen_d = bekleyen_q + BK_W'(1);
      2'b01:   bekleyen_d = bekleyen_q - BK_W'(1);
      default: bekleyen_d = bekleyen_q;
    endcase

    // Every request still outstanding after this cycle's response was issued
    // before the flush, so all of their responses are stale. A request made in
    // the flush cycle itself is not counted here.
    if (cek_bosalt_i) begin
      dusur_d = bekleyen_q - BK_W'(yanit_pop);
    end else if (yanit_pop && (dusur_q != '0)) begin
      dusur_d = dusur_q - BK_W'(1);
    end
  end

  // Parcel write side. A word fetched for a PS with bit 1 set carries only one
  // useful parcel, its upper half.
  always_comb begin
    yaz0_en   = 1'b0;
    yaz1_en   = 1'b0;
    yaz0_adr  = pq_yaz_q;
    yaz1_adr  = pq_yaz_q + QA_W'(1);
    yaz0_veri = l1b_buyruk_i[15:0];
    yaz1_veri = l1b_buyruk_i[31:16];
    yaz0_ps   = ps_hizali;
    yaz1_ps   = ps_ust;
    yaz_n     = 2'd0;
    if (yanit_sakla) begin
      if (bas_ps[1]) begin
        yaz0_en   = 1'b1;
        yaz0_veri = l1b_buyruk_i[31:16];
        yaz0_ps   = ps_ust;
        yaz_n     = 2'd1;
      end else begin
        yaz0_en = 1'b1;
        yaz1_en = 1'b1;
        yaz_n   = 2'd2;
      end
    end
  end

  // Assembly and output register. Only registered occupancy is used, so a
  // parcel written this cycle becomes visible to assembly next cycle.
  always_comb begin
    cikis_bos = !cgec_q || coz_buyruk_hazir_i;
    p0        = pq_veri_q[pq_oku_q];
    p1        = pq_veri_q[pq_oku_q + QA_W'(1)];
    p0_sik    = (p0[1:0] != 2'b11);

    cb_d   = cb_q;
    cps_d  = cps_q;
    csk_d  = csk_q;
    cgec_d = cgec_q;
    oku_n  = 2'd0;

    if (cikis_bos) begin
      cgec_d = 1'b0;
      if ((pq_dolu_q != '0) && p0_sik) begin
        cb_d   = {16'h0000, p0};
        cps_d  = pq_ps_q[pq_oku_q];
        csk_d  = 1'b1;
        cgec_d = 1'b1;
        oku_n  = 2'd1;
      end else if ((pq_dolu_q >= QO_W'(2)) && !p0_sik) begin
        cb_d   = {p1, p0};
        cps_d  = pq_ps_q[pq_oku_q];
        csk_d  = 1'b0;
        cgec_d = 1'b1;
        oku_n  = 2'd2;
      end
    end

    pq_yaz_d  = pq_yaz_q + QA_W'(yaz_n);
    pq_oku_d  = pq_oku_q + QA_W'(oku_n);
    pq_dolu_d = pq_dolu_q + QO_W'(yaz_n) - QO_W'(oku_n);

    if (cek_bosalt_i) begin
      cgec_d    = 1'b0;
      pq_yaz_d  = '0;
      pq_oku_d  = '0;
      pq_dolu_d = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      rq_yaz_q   <= '0;
      rq_oku_q   <= '0;
      bekleyen_q <= '0;
      dusur_q    <= '0;
      pq_yaz_q   <= '0;
      pq_oku_q   <= '0;
      pq_dolu_q  <= '0;
      cb_q       <= '0;
      cps_q      <= '0;
      csk_q      <= 1'b0;
      cgec_q     <= 1'b0;
    end else begin
      rq_yaz_q   <= rq_yaz_d;
      rq_oku_q   <= rq_oku_d;
      bekleyen_q <= bekleyen_d;
      dusur_q    <= dusur_d;
      pq_yaz_q   <= pq_yaz_d;
      pq_oku_q   <= pq_oku_d;
      pq_dolu_q  <= pq_dolu_d;
      cb_q       <= cb_d;
      cps_q      <= cps_d;
      csk_q      <= csk_d;
      cgec_q     <= cgec_d;
    end
  end

  // Storage arrays need no reset: their contents are only read through
  // pointers and occupancy, which are reset.
  always_ff @(posedge clk_i) begin
    if (istek_kabul) begin
      rq_mem_q[rq_yaz_q] <= g1_istek_ps_i;
    end
    if (yaz0_en) begin
      pq_veri_q[yaz0_adr] <= yaz0_veri;
      pq_ps_q[yaz0_adr]   <= yaz0_ps;
    end
    if (yaz1_en) begin
      pq_veri_q[yaz1_adr] <= yaz1_veri;
      pq_ps_q[yaz1_adr]   <= yaz1_ps;
    end
  end

  assign coz_buyruk_o               = cb_q;
  assign coz_buyruk_ps_o            = cps_q;
  assign coz_buyruk_sikistirilmis_o = csk_q;
  assign coz_buyruk_gecerli_o       = cgec_q;

endmodule

// File: tb/tb_buyruk_hizalayici.sv
// Testbench for buyruk_hizalayici.
//
// Reference model, kept at request and parcel level:
//   - A list of outstanding requests. A flush marks every entry in the list stale.
//   - A list of kept parcels.
//   - An expected-instruction queue, assembled greedily from the parcel list.
//
// The getir1 and L1 sides are driven by the bench. L1 answers outstanding
// requests in order, with words taken from a small address-keyed word memory.
module tb_buyruk_hizalayici;
  localparam int PS_BIT = 32;
  localparam int MAKS   = 3;

  logic              clk_i = 1'b0;
  logic              rstn_i;
  logic              g1_istek_yapildi_i;
  logic [PS_BIT-1:0] g1_istek_ps_i;
  logic              g1_istek_izin_o;
  logic [31:0]       l1b_buyruk_i;
  logic              l1b_buyruk_gecerli_i;
  logic              l1b_buyruk_hazir_o;
  logic [31:0]       coz_buyruk_o;
  logic [PS_BIT-1:0] coz_buyruk_ps_o;
  logic              coz_buyruk_sikistirilmis_o;
  logic              coz_buyruk_gecerli_o;
  logic              coz_buyruk_hazir_i;
  logic              cek_bosalt_i;

  // ---------------------------------------------------------------------------
  // Clock
  // ---------------------------------------------------------------------------
  always #5 clk_i = ~clk_i;

  buyruk_hizalayici #(
    .PS_BIT(PS_BIT), .KUYRUK_DERINLIK(8), .MAKS_BEKLEYEN(MAKS)
  ) dut (
    .clk_i(clk_i),
    .rstn_i(rstn_i),
    .g1_istek_yapildi_i(g1_istek_yapildi_i),
    .g1_istek_ps_i(g1_istek_ps_i),
    .g1_istek_izin_o(g1_istek_izin_o),
    .l1b_buyruk_i(l1b_buyruk_i),
    .l1b_buyruk_gecerli_i(l1b_buyruk_gecerli_i),
    .l1b_buyruk_hazir_o(l1b_buyruk_hazir_o),
    .coz_buyruk_o(coz_buyruk_o),
    .coz_buyruk_ps_o(coz_buyruk_ps_o),
    .coz_buyruk_sikistirilmis_o(coz_buyruk_sikistirilmis_o),
    .coz_buyruk_gecerli_o(coz_buyruk_gecerli_o),
    .coz_buyruk_hazir_i(coz_buyruk_hazir_i),
    .cek_bosalt_i(cek_bosalt_i)
  );

  // ---------------------------------------------------------------------------
  // Reference model state
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [31:0] ps;
    bit          stale;
  } istek_t;

  istek_t      m_req[$];
  logic [47:0] plist[$];       // {ps, parcel}
  logic [64:0] exp_q[$];       // {sikistirilmis, ps, instruction}
  logic [31:0] wmem [logic [31:0]];

  int total = 0;
  int bad   = 0;

  // Per-cycle drive values
  logic        d_req, d_rsp, d_rdy, d_flush, d_rstn;
  logic [31:0] d_ps;
  // Per-cycle observations used by the model update
  bit          s_push, s_acc, s_hs;
  logic [31:0] m_pc;

  function automatic logic [31:0] word_of(input logic [31:0] ps);
    logic [31:0] a;
    logic [31:0] x;
    a = ps & ~32'h3;
    if (wmem.exists(a)) return wmem[a];
    x = a * 32'h9E3779B1;
    x = x ^ (x >> 13);
    x = x * 32'h85EBCA6B;
    return x ^ (x >> 16);
  endfunction

  task automatic chk(input string tag, input logic [64:0] obs, input logic [64:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  function automatic void assemble();
    while (plist.size() > 0) begin
      if (plist[0][1:0] != 2'b11) begin
        exp_q.push_back({1'b1, plist[0][47:16], 16'h0000, plist[0][15:0]});
        plist.delete(0);
      end else if (plist.size() >= 2) begin
        exp_q.push_back({1'b0, plist[0][47:16], plist[1][15:0], plist[0][15:0]});
        plist.delete(0);
        plist.delete(0);
      end else begin
        break;
      end
    end
  endfunction

  // ---------------------------------------------------------------------------
  // Driver: one clock cycle, starting and ending at a falling edge
  // ---------------------------------------------------------------------------
  task automatic cyc();
    istek_t      e;
    logic [31:0] w;
    logic [31:0] base;
    g1_istek_yapildi_i   = d_req;
    g1_istek_ps_i        = d_ps;
    l1b_buyruk_gecerli_i = d_rsp && (m_req.size() != 0);
    l1b_buyruk_i         = (m_req.size() != 0) ? word_of(m_req[0].ps) : 32'h0;
    coz_buyruk_hazir_i   = d_rdy;
    cek_bosalt_i         = d_flush;
    rstn_i               = d_rstn;
    #1;
    s_push = 1'b0;
    s_acc  = 1'b0;
    s_hs   = 1'b0;
    if (d_rstn) begin
      chk("izin", g1_istek_izin_o, m_req.size() < MAKS);
      s_push = d_req && (m_req.size() < MAKS);
      s_acc  = l1b_buyruk_gecerli_i && l1b_buyruk_hazir_o;
      s_hs   = coz_buyruk_gecerli_o && d_rdy;
      if (s_hs) begin
        if (exp_q.size() == 0) begin
          chk("beklenmeyen_cikis", coz_buyruk_gecerli_o, 1'b0);
        end else begin
          chk("cikis", {coz_buyruk_sikistirilmis_o, coz_buyruk_ps_o, coz_buyruk_o}, exp_q[0]);
          exp_q.delete(0);
        end
      end
    end else begin
      chk("hazir_resette", l1b_buyruk_hazir_o, 1'b0);
    end
    @(posedge clk_i);
    if (!d_rstn) begin
      m_req.delete();
      plist.delete();
      exp_q.delete();
    end else begin
      if (s_acc) begin
        e = m_req.pop_front();
        if (!e.stale && !d_flush) begin
          w    = word_of(e.ps);
          base = e.ps & ~32'h3;
          if (!e.ps[1]) plist.push_back({base, w[15:0]});
          plist.push_back({base | 32'h2, w[31:16]});
        end
      end
      if (d_flush) begin
        foreach (m_req[i]) m_req[i].stale = 1'b1;
        plist.delete();
        exp_q.delete();
      end
      if (s_push) m_req.push_back('{ps: d_ps, stale: 1'b0});
      assemble();
    end
    @(negedge clk_i);
  endtask

  task automatic st(input bit rq, input logic [31:0] ps, input bit rs, input bit rdy, input bit fl);
    d_req   = rq;
    d_ps    = ps;
    d_rsp   = rs;
    d_rdy   = rdy;
    d_flush = fl;
    cyc();
  endtask

  task automatic chk_out(input string tag, input logic [31:0] ins, input logic [31:0] ps, input logic s);
    chk({tag, "_gecerli"}, coz_buyruk_gecerli_o, 1'b1);
    chk(tag, {coz_buyruk_sikistirilmis_o, coz_buyruk_ps_o, coz_buyruk_o}, {s, ps, ins});
  endtask

  // ---------------------------------------------------------------------------
  // Directed sequence, random phase, drain, final reset, report
  // ---------------------------------------------------------------------------
  initial begin
    d_rstn = 1'b0;
    st(0, 0, 0, 0, 0);
    st(0, 0, 0, 0, 0);
    chk("rst_buyruk", coz_buyruk_o, 32'h0);
    chk("rst_ps", coz_buyruk_ps_o, 32'h0);
    chk("rst_sik", coz_buyruk_sikistirilmis_o, 1'b0);
    chk("rst_gecerli", coz_buyruk_gecerli_o, 1'b0);
    chk("rst_izin", g1_istek_izin_o, 1'b1);
    chk("rst_hazir", l1b_buyruk_hazir_o, 1'b0);
    d_rstn = 1'b1;
    st(0, 0, 0, 0, 0);
    chk("rst_sonra_hazir", l1b_buyruk_hazir_o, 1'b1);

    // Aligned mix
    wmem[32'h100] = 32'h4501_0513;
    wmem[32'h104] = 32'h0002_0001;
    st(1, 32'h100, 0, 0, 0);
    st(1, 32'h104, 0, 0, 0);
    st(0, 0, 1, 0, 0);
    chk("hizali_gecikme", coz_buyruk_gecerli_o, 1'b0);
    st(0, 0, 1, 0, 0);
    chk_out("hizali_0", 32'h4501_0513, 32'h100, 1'b0);
    st(0, 0, 0, 1, 0);
    chk_out("hizali_1", 32'h0000_0001, 32'h104, 1'b1);
    st(0, 0, 0, 1, 0);
    chk_out("hizali_2", 32'h0000_0002, 32'h106, 1'b1);
    st(0, 0, 0, 1, 0);
    chk("hizali_bos", coz_buyruk_gecerli_o, 1'b0);

    // Straddle
    wmem[32'h200] = 32'h0513_ABCD;
    wmem[32'h204] = 32'h0001_4501;
    st(1, 32'h202, 0, 0, 0);
    st(1, 32'h204, 0, 0, 0);
    st(0, 0, 1, 0, 0);
    chk("tasma_bekle1", coz_buyruk_gecerli_o, 1'b0);
    st(0, 0, 1, 0, 0);
    chk("tasma_bekle2", coz_buyruk_gecerli_o, 1'b0);
    st(0, 0, 0, 0, 0);
    chk_out("tasma_32", 32'h4501_0513, 32'h202, 1'b0);
    st(0, 0, 0, 1, 0);
    chk_out("tasma_16", 32'h0000_0001, 32'h206, 1'b1);
    st(0, 0, 0, 1, 0);
    chk("tasma_bos", coz_buyruk_gecerli_o, 1'b0);

    // Backpressure with eight compressed parcels
    for (int k = 0; k < 4; k++) begin
      wmem[32'h300 + 32'(4 * k)] = {16'h1001 + 16'((2 * k + 1) * 16), 16'h1001 + 16'(2 * k * 16)};
    end
    st(1, 32'h300, 0, 0, 0);
    st(1, 32'h304, 0, 0, 0);
    st(1, 32'h308, 0, 0, 0);
    chk("bp_izin_dolu", g1_istek_izin_o, 1'b0);
    st(1, 32'h30C, 1, 0, 0);   // request while izin is low: ignored
    st(1, 32'h30C, 1, 0, 0);
    st(0, 0, 1, 0, 0);
    st(0, 0, 1, 0, 0);
    chk("bp_hazir", l1b_buyruk_hazir_o, 1'b0);
    for (int k = 0; k < 3; k++) begin
      chk_out("bp_sabit", 32'h0000_1001, 32'h300, 1'b1);
      st(0, 0, 0, 0, 0);
    end
    for (int k = 0; k < 8; k++) begin
      chk_out("bp_akis", 32'h0000_1001 + 32'(16 * k), 32'h300 + 32'(2 * k), 1'b1);
      st(0, 0, 0, 1, 0);
    end
    chk("bp_bos", coz_buyruk_gecerli_o, 1'b0);

    // Flush with three outstanding requests
    wmem[32'h400] = 32'h0000_0001;
    st(1, 32'h500, 0, 1, 0);
    st(1, 32'h504, 0, 1, 0);
    st(1, 32'h508, 0, 1, 0);
    chk("fl_izin_dolu", g1_istek_izin_o, 1'b0);
    st(0, 0, 0, 1, 1);
    chk("fl_izin_hala_dolu", g1_istek_izin_o, 1'b0);
    st(0, 0, 1, 1, 0);
    chk("fl_izin_acik", g1_istek_izin_o, 1'b1);
    st(1, 32'h400, 1, 1, 0);
    st(0, 0, 1, 1, 0);
    chk("fl_dusur", coz_buyruk_gecerli_o, 1'b0);
    st(0, 0, 1, 1, 0);
    chk("fl_dusur_son", coz_buyruk_gecerli_o, 1'b0);
    st(0, 0, 0, 1, 0);
    chk_out("fl_yeni", 32'h0000_0001, 32'h400, 1'b1);
    st(0, 0, 0, 1, 0);
    st(0, 0, 0, 1, 0);

    // Flush-cycle collisions with two outstanding
    wmem[32'h604] = 32'h0011_0011;
    wmem[32'h700] = 32'h0005_0009;
    st(1, 32'h600, 0, 1, 0);
    st(1, 32'h604, 0, 1, 0);
    st(1, 32'h700, 1, 1, 1);
    st(0, 0, 1, 1, 0);
    st(0, 0, 1, 1, 0);
    chk("cakis_dusur", coz_buyruk_gecerli_o, 1'b0);
    st(0, 0, 0, 1, 0);
    chk_out("cakis_sakla", 32'h0000_0009, 32'h700, 1'b1);
    st(0, 0, 0, 1, 0);
    st(0, 0, 0, 1, 0);

    // Random traffic against the model
    m_pc = 32'h1000;
    for (int n = 0; n < 3000; n++) begin
      d_flush = ($urandom_range(0, 99) < 3);
      if (d_flush) m_pc = $urandom_range(0, 32'h7FFF) << 1;
      d_req = ($urandom_range(0, 99) < 60);
      d_ps  = m_pc;
      d_rsp = ($urandom_range(0, 99) < 70);
      d_rdy = ($urandom_range(0, 99) < 75);
      cyc();
      if (s_push) m_pc = (m_pc & ~32'h3) + 32'h4;
    end
    for (int n = 0; n < 60; n++) st(0, 0, 1, 1, 0);
    chk("bosaltma_kalan", exp_q.size(), 0);

    // Reset mid-stream with a full queue and a valid output
    st(0, 0, 0, 1, 1);
    m_pc = 32'h800;
    for (int n = 0; n < 20; n++) begin
      st(m_req.size() < MAKS, m_pc, m_req.size() != 0, 0, 0);
      if (s_push) m_pc = m_pc + 32'h4;
    end
    chk("dolu_hazir", l1b_buyruk_hazir_o, 1'b0);
    chk("dolu_gecerli", coz_buyruk_gecerli_o, 1'b1);
    d_rstn = 1'b0;
    st(0, 0, 1, 0, 0);
    chk("ara_rst_buyruk", coz_buyruk_o, 32'h0);
    chk("ara_rst_ps", coz_buyruk_ps_o, 32'h0);
    chk("ara_rst_sik", coz_buyruk_sikistirilmis_o, 1'b0);
    chk("ara_rst_gecerli", coz_buyruk_gecerli_o, 1'b0);
    chk("ara_rst_izin", g1_istek_izin_o, 1'b1);
    chk("ara_rst_hazir", l1b_buyruk_hazir_o, 1'b0);
    d_rstn = 1'b1;
    st(0, 0, 0, 1, 0);
    chk("ara_rst_sonra_hazir", l1b_buyruk_hazir_o, 1'b1);
    chk("ara_rst_sonra_gecerli", coz_buyruk_gecerli_o, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/buyruk_hizalayici.md
# buyruk_hizalayici

Parametrised fetch-stage-2 instruction aligner between getir1/L1 instruction cache and the decode stage. It tracks outstanding L1 requests and their PS values in request order, and splits each returned 32-bit word into 16-bit parcels held in a parcel queue. It re-assembles RV32IC instructions, compressed or 32-bit, including 32-bit instructions that straddle two fetch words. Decode gets one instruction per cycle over a valid/ready handshake. A flush drops all stale in-flight responses.

## Interface
- PS_BIT, 32, program-counter width.
- KUYRUK_DERINLIK, 8, parcel-queue depth in 16-bit parcels; power of two, ≥4.
- MAKS_BEKLEYEN, 3, maximum outstanding L1 requests; ≥1.
- clk_i  in  1  clock; single clock domain.
- rstn_i  in  1  reset; synchronous, active-low.
- g1_istek_yapildi_i  in  1  getir1 issued an L1 request this cycle.
- g1_istek_ps_i  in  PS_BIT  PS of that request; bit 0 is always 0.
- g1_istek_izin_o  out  1  request permitted: outstanding count < MAKS_BEKLEYEN.
- l1b_buyruk_i  in  32  returned fetch word; parcel 0 is [15:0], parcel 1 is [31:16].
- l1b_buyruk_gecerli_i  in  1  response valid.
- l1b_buyruk_hazir_o  out  1  response accept.
- coz_buyruk_o  out  32  instruction; compressed instructions are zero-extended in [15:0].
- coz_buyruk_ps_o  out  PS_BIT  PS of the instruction's first parcel.
- coz_buyruk_sikistirilmis_o  out  1  instruction is 16-bit.
- coz_buyruk_gecerli_o  out  1  output valid.
- coz_buyruk_hazir_i  in  1  decode ready.
- cek_bosalt_i  in  1  pipeline flush; single-cycle pulse.

## Operation
- **Request queue.** FIFO of MAKS_BEKLEYEN PS entries. Push g1_istek_ps_i when g1_istek_yapildi_i && g1_istek_izin_o. A request made while izin is low is a protocol violation: it is ignored, nothing is pushed and nothing is counted.
- **Outstanding counter.**
  - Width is clog2(MAKS_BEKLEYEN+1).
  - +1 on push, −1 on response accept, unchanged when both happen in the same cycle.
  - Response accept = l1b_buyruk_gecerli_i && l1b_buyruk_hazir_o. Every accept pops the request queue.
- **Normal accept.** l1b_buyruk_hazir_o = rstn_i && (drop count ≠ 0 || free parcels ≥ 2).
  - Free parcels are computed from registered occupancy only; same-cycle pops give no credit.
  - Parcel PS: parcel 0 = (req_ps & ~3), parcel 1 = (req_ps & ~3) + 2.
  - If req_ps[1] = 1, parcel 0 is discarded and only parcel 1 is written.
  - Parcels are written in order, parcel 0 first.
- **Drop mode.** While drop count ≠ 0, accepted responses are discarded and do not write the parcel queue. The drop count decrements on each accept.
- **Assembly.** Head parcel p0 is compressed iff p0[1:0] ≠ 2'b11. When the output register is empty, or is emptied this cycle (gecerli && hazir), load it as follows:
  - If p0 is compressed: load {16'b0, p0}, PS(p0), sikistirilmis=1, and pop 1 parcel.
  - If p0 is not compressed and occupancy ≥ 2: load {p1, p0}, PS(p0), sikistirilmis=0, and pop 2 parcels.
  - Otherwise: load nothing; gecerli falls if it was consumed.
- **Output hold.** While gecerli && !hazir, all coz_* outputs hold stable.
- **Flush (cek_bosalt_i = 1).**
  - Next cycle: parcel queue empty; coz_buyruk_gecerli_o = 0.
  - Drop count = outstanding_r − (accept this cycle ? 1 : 0).
  - A response accepted in the flush cycle is discarded.
  - A request issued in the flush cycle is post-flush: it is pushed and its response is kept.
  - A flush during drop mode recomputes the drop count with the same formula.
- **Parcel-queue pointers.** Wrap modulo KUYRUK_DERINLIK. Occupancy counter width is clog2(KUYRUK_DERINLIK+1).

## Timing
- Reset values:
  - coz_buyruk_o, coz_buyruk_ps_o, coz_buyruk_sikistirilmis_o, coz_buyruk_gecerli_o = 0.
  - Outstanding count, drop count, queue occupancies = 0.
  - l1b_buyruk_hazir_o = 0 while rstn_i is low.
  - g1_istek_izin_o = 1.
- Reset mid-operation discards all in-flight state. The L1 side is reset together with this block.
- Latency: response accepted at edge t → parcels in queue after t → coz_buyruk_gecerli_o high from cycle t+1 (the output register loads at edge t+1). No bypass from l1b to the coz outputs.
- Throughput: one instruction per cycle while parcels are available. Queue write is ≤2 parcels/cycle; queue read is ≤2 parcels/cycle.
- A straddling 32-bit instruction waits in the queue until its second parcel arrives. No bubble is inserted beyond that wait.
- g1_istek_izin_o and l1b_buyruk_hazir_o are combinational from registered state (plus rstn_i). They do not depend on gecerli in the same cycle.

## Test plan
- **Aligned mix.** Request PS 0x100, then 0x104. Words 0x4501_0513 (parcel 0 = 0x0513, 32-bit) and 0x0002_0001.
  - Output: 0x4501_0513 @0x100, s=0.
  - Then 0x0001 @0x104, s=1.
  - Then 0x0002 @0x106, s=1.
- **Straddle.** Request PS 0x202, word 0x0513_xxxx; then PS 0x204, word 0x0001_4501.
  - Output: 0x4501_0513 @0x202, s=0.
  - The instruction appears only after the second accept.
- **Backpressure.** Hold coz_buyruk_hazir_i = 0 with 8 compressed parcels queued.
  - l1b_buyruk_hazir_o = 0; outputs stable.
  - Release hazir: one instruction per cycle, PS increments by 2.
- **Flush with outstanding requests.** 3 requests outstanding, none returned; flush; one new request @0x400.
  - First 3 responses are dropped.
  - 4th response is emitted with PS 0x400.
  - g1_istek_izin_o is low only while the outstanding count is 3.
- **Flush-cycle collisions.** Response accepted and request issued in the same cycle as the flush, with 2 outstanding.
  - Drop count becomes 1.
  - The new request's response is kept.
- **Reset mid-stream.** Pull rstn_i low with a full queue and valid output.
  - Next cycle: all outputs 0, izin = 1.
